// File: rtl/spi_slave_cfg_if.sv
// spi_slave_cfg_if: SPI pin bundle between an external master and the slave
interface spi_slave_cfg_if;
  logic SCK;
  logic SSEL;
  logic MOSI;
  logic MISO;
  logic MISO_oe;
  modport master (output SCK, SSEL, MOSI, input MISO, MISO_oe);
  modport slave (input SCK, SSEL, MOSI, output MISO, MISO_oe);
endinterface

// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: parametrised full-duplex SPI slave with burst frames, TX reload handshake and abort detection
module spi_slave_cfg #(
  parameter int FRAME_BITS = 16,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_cfg_if.slave        spi,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [2:0] sck_s, ss_s;
  logic [1:0] mosi_s;
  logic [CW-1:0] cnt;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic first, reload;
  logic sck_rise, sck_fall, smp, shf, ss_fall, ss_rise;
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign smp = (CPHA ^ CPOL) ? sck_fall : sck_rise;
  assign shf = (CPHA ^ CPOL) ? sck_rise : sck_fall;
  assign ss_fall = ~ss_s[1] & ss_s[2];
  assign ss_rise = ss_s[1] & ~ss_s[2];
  assign busy = state == XFER;
  assign spi.MISO = tx_sr[FRAME_BITS-1];
  assign spi.MISO_oe = busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sck_s <= {3{CPOL}};
      ss_s <= 3'b111;
      mosi_s <= 2'b00;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      first <= 1'b0;
      reload <= 1'b0;
      tx_load <= 1'b0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], spi.SCK};
      ss_s <= {ss_s[1:0], spi.SSEL};
      mosi_s <= {mosi_s[0], spi.MOSI};
      tx_load <= 1'b0;
      rx_valid <= 1'b0;
      frame_error <= 1'b0;
      if (ss_fall) begin
        state <= XFER;
        tx_sr <= tx_data;
        tx_load <= 1'b1;
        cnt <= '0;
        first <= CPHA;
        reload <= 1'b0;
      end else if (ss_rise) begin
        state <= IDLE;
        frame_error <= cnt != '0;
        cnt <= '0;
        first <= 1'b0;
        reload <= 1'b0;
      end else if (state == XFER) begin
        if (smp) begin
          rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s[1]};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            rx_data <= {rx_sr[FRAME_BITS-2:0], mosi_s[1]};
            rx_valid <= 1'b1;
            reload <= 1'b1;
          end
        end
        // a wrapped frame replaces its next shift with a reload of the following word
        if (shf) begin
          if (reload) begin
            tx_sr <= tx_data;
            tx_load <= 1'b1;
            reload <= 1'b0;
          end else if (first) begin
            first <= 1'b0;
          end else begin
            tx_sr <= tx_sr << 1;
          end
        end
      end
    end
  end
endmodule
